// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded control word and operands, detects
// load-use hazards, inserts bubbles on stall or flush, and counts the bubbles inserted.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iHold,
    input  logic              iFlush,
    input  logic [CTRL_W-1:0] iCtrl,
    input  logic [XLEN-1:0]   iPC,
    input  logic [XLEN-1:0]   iRs1Data,
    input  logic [XLEN-1:0]   iRs2Data,
    input  logic [XLEN-1:0]   iImm,
    input  logic [4:0]        iRs1,
    input  logic [4:0]        iRs2,
    input  logic [4:0]        iRd,
    input  logic              iUseRs1,
    input  logic              iUseRs2,
    input  logic [2:0]        iFunct3,
    input  logic              iFunct7b5,
    output logic [CTRL_W-1:0] oCtrl,
    output logic [XLEN-1:0]   oPC,
    output logic [XLEN-1:0]   oRs1Data,
    output logic [XLEN-1:0]   oRs2Data,
    output logic [XLEN-1:0]   oImm,
    output logic [4:0]        oRs1,
    output logic [4:0]        oRs2,
    output logic [4:0]        oRd,
    output logic [2:0]        oFunct3,
    output logic              oFunct7b5,
    output logic              oStall,
    output logic [CNT_W-1:0]  oBubbles
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              funct7b5_q, funct7b5_d;
    logic [CNT_W-1:0]  bubbles_q, bubbles_d;
    logic              lu_s, load_s, bubble_s;

    // Load-use hazard: the instruction in EX is a load whose rd (non-x0) is read in ID
    always_comb begin
        lu_s = 1'b0;
        if (ctrl_q[3] && (rd_q != 5'd0) &&
            ((iUseRs1 && (iRs1 == rd_q)) || (iUseRs2 && (iRs2 == rd_q)))) begin
            lu_s = 1'b1;
        end else begin
            lu_s = 1'b0;
        end
    end

    assign oStall   = lu_s & ~iFlush;
    assign load_s   = ~iHold;
    assign bubble_s = ~iHold & (iFlush | lu_s);

    // Next-state: hold keeps everything; otherwise data loads and control may be squashed
    always_comb begin
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        bubbles_d  = bubbles_q;
        if (load_s) begin
            ctrl_d     = bubble_s ? {CTRL_W{1'b0}} : iCtrl;
            pc_d       = iPC;
            rs1_data_d = iRs1Data;
            rs2_data_d = iRs2Data;
            imm_d      = iImm;
            rs1_d      = iRs1;
            rs2_d      = iRs2;
            rd_d       = iRd;
            funct3_d   = iFunct3;
            funct7b5_d = iFunct7b5;
        end else begin
            ctrl_d     = ctrl_q;
        end
        // Counter wraps naturally at 2^CNT_W
        if (bubble_s) begin
            bubbles_d = bubbles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubbles_d = bubbles_q;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ctrl_q     <= {CTRL_W{1'b0}};
            pc_q       <= {XLEN{1'b0}};
            rs1_data_q <= {XLEN{1'b0}};
            rs2_data_q <= {XLEN{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
            bubbles_q  <= {CNT_W{1'b0}};
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            bubbles_q  <= bubbles_d;
        end
    end

    assign oCtrl     = ctrl_q;
    assign oPC       = pc_q;
    assign oRs1Data  = rs1_data_q;
    assign oRs2Data  = rs2_data_q;
    assign oImm      = imm_q;
    assign oRs1      = rs1_q;
    assign oRs2      = rs2_q;
    assign oRd       = rd_q;
    assign oFunct3   = funct3_q;
    assign oFunct7b5 = funct7b5_q;
    assign oBubbles  = bubbles_q;

endmodule
